// File: rtl/dmux8_dispatch_ctrl.sv
// Round-robin dispatcher for the 8-way demux.
// Buffers one producer word, locks it onto the next enabled channel in rotation
// and holds sel/out_data stable until that channel's consumer takes it.
// Optional feature macro: DMUX8_DISPATCH_STATS_EN adds per-channel delivery counters
// readable through stat_sel/stat_count.
module dmux8_dispatch_ctrl #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       ch_enable,
    output logic [2:0]       sel,
    output logic [WIDTH-1:0] out_data,
    output logic [7:0]       out_valid,
    input  logic [7:0]       out_ready
`ifdef DMUX8_DISPATCH_STATS_EN
    ,
    input  logic [2:0]       stat_sel,
    output logic [15:0]      stat_count
`endif
);

    typedef enum logic [1:0] {StEmpty, StSeek, StSend} state_e;

    state_e           state_q, state_d;
    logic [2:0]       ptr_q, ptr_d;
    logic [2:0]       sel_q, sel_d;
    logic [WIDTH-1:0] data_q, data_d;

    logic [2:0] base;
    logic [2:0] next_tgt;
    logic       any_en;
    logic       hs;

    assign any_en = |ch_enable;
    // Only the locked channel's ready matters; other bits are ignored.
    assign hs     = out_ready[sel_q];

    // Rotating priority search. While sending, a retarget starts after the
    // channel just served, i.e. from the post-handshake pointer.
    always_comb begin
        base     = (state_q == StSend) ? sel_q + 3'd1 : ptr_q;
        next_tgt = base;
        // Walk downwards so the closest enabled channel to base wins.
        for (int k = 7; k >= 0; k--) begin
            if (ch_enable[base + 3'(k)]) begin
                next_tgt = base + 3'(k);
            end
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        sel_d     = sel_q;
        data_d    = data_q;
        in_ready  = 1'b0;
        out_valid = 8'h00;

        case (state_q)
            StEmpty: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    data_d = in_data;
                    if (any_en) begin
                        sel_d   = next_tgt;
                        state_d = StSend;
                    end else begin
                        state_d = StSeek;
                    end
                end
            end
            StSeek: begin
                if (any_en) begin
                    sel_d   = next_tgt;
                    state_d = StSend;
                end
            end
            StSend: begin
                out_valid = 8'h01 << sel_q;
                in_ready  = hs;
                if (hs) begin
                    ptr_d = sel_q + 3'd1;
                    if (in_valid) begin
                        data_d = in_data;
                        if (any_en) begin
                            sel_d   = next_tgt;
                            state_d = StSend;
                        end else begin
                            state_d = StSeek;
                        end
                    end else begin
                        state_d = StEmpty;
                    end
                end
            end
            default: state_d = StEmpty;
        endcase

        // No transfer in either direction is advertised while in reset.
        if (reset) begin
            in_ready  = 1'b0;
            out_valid = 8'h00;
        end
    end

    // State register with synchronous reset; a held word is dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StEmpty;
            ptr_q   <= 3'd0;
            sel_q   <= 3'd0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
        end
    end

    assign sel      = sel_q;
    assign out_data = data_q;

`ifdef DMUX8_DISPATCH_STATS_EN
    logic [15:0] cnt_q [8];

    // Saturating per-channel delivery counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < 8; k++) begin
                cnt_q[k] <= 16'h0000;
            end
        end else if (state_q == StSend && hs && cnt_q[sel_q] != 16'hFFFF) begin
            cnt_q[sel_q] <= cnt_q[sel_q] + 16'd1;
        end
    end

    assign stat_count = cnt_q[stat_sel];
`endif

endmodule
